// File: rtl/phy_link_nlane_pkg.sv
// Shared line symbols, FSM state codes and the debug view for the N-lane PHY link.
// Build option PHY_LINK_ERR_CNT_EN (see phy_link_nlane.sv) adds an idle-error counter port.
package phy_link_nlane_pkg;

    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] STP = 8'hFB;

    localparam logic [1:0] TX_IDLE = 2'd0;
    localparam logic [1:0] TX_STP  = 2'd1;
    localparam logic [1:0] TX_DATA = 2'd2;

    localparam logic [1:0] RX_SEARCH = 2'd0;
    localparam logic [1:0] RX_IDLE   = 2'd1;
    localparam logic [1:0] RX_DATA   = 2'd2;

    typedef struct packed {
        logic [1:0] tx_state;
        logic [1:0] rx_state;
        logic [2:0] bit_cnt;
    } dbg_t;

endpackage

// File: rtl/phy_link_nlane_if.sv
// Parallel-side bundle between the link layer (master) and the PHY (slave).
// Handshake: a word transfers on each clk_32f edge where valid_in && ready_out; data_in holds while valid_in waits.
interface phy_link_nlane_if #(
    parameter int DATA_W = 32
) ();
    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic              ready_out;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              locked;

    modport master (output data_in, valid_in, input ready_out, data_out, valid_out, locked);
    modport slave  (input data_in, valid_in, output ready_out, data_out, valid_out, locked);
endinterface

// File: rtl/phy_lane_rx.sv
// One RX lane: MSB-first shift register, byte-boundary COM/STP flags and payload slot capture.
module phy_lane_rx
    import phy_link_nlane_pkg::*;
#(
    parameter int BPL = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in,
    input  logic             capture,
    output logic             is_com,
    output logic             is_stp,
    output logic [BPL*8-1:0] lane_word
);
    logic [6:0] shreg;
    logic [7:0] byte_now;

    // byte_now includes the bit arriving this cycle, so decisions land on the boundary edge
    assign byte_now = {shreg, serial_in};
    assign is_com   = (byte_now == COM);
    assign is_stp   = (byte_now == STP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) shreg <= '0;
        else        shreg <= byte_now[6:0];
    end

    if (BPL == 1) begin : g_one
        assign lane_word = byte_now;
    end else begin : g_multi
        logic [(BPL-1)*8-1:0] slots;
        assign lane_word = {slots, byte_now};
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)       slots <= '0;
            else if (capture) slots <= lane_word[(BPL-1)*8-1:0];
        end
    end

endmodule

// File: rtl/phy_link_nlane.sv
// N-lane PHY link: TX stripes words byte-wise across lanes behind an STP byte, RX aligns on COM and reassembles.
// Define PHY_LINK_ERR_CNT_EN to add err_cnt, a saturating count of bad idle-boundary bytes.
module phy_link_nlane
    import phy_link_nlane_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int LANES     = 2,
    parameter int LOCK_LOSS = 4
) (
    input  logic             clk_32f,
    input  logic             reset,
    phy_link_nlane_if.slave  link,
    output logic [LANES-1:0] serial_out,
    input  logic [LANES-1:0] serial_in,
    output dbg_t             dbg
`ifdef PHY_LINK_ERR_CNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);
    localparam int BPL  = DATA_W / (8 * LANES);
    localparam int SW   = (BPL > 1) ? $clog2(BPL) : 1;
    localparam int BADW = $clog2(LOCK_LOSS + 1);

    if (LANES < 1 || (DATA_W % (8 * LANES)) != 0 || LOCK_LOSS < 1) begin : g_bad_cfg
        $error("phy_link_nlane: DATA_W must be a multiple of 8*LANES");
    end

    // ---------------- TX ----------------
    logic [2:0]        bit_cnt;
    logic [1:0]        tx_state, tx_nstate;
    logic [SW-1:0]     tx_slot, tx_nslot;
    logic              tx_pend, tx_last, accept;
    logic [DATA_W-1:0] tx_word;

    assign tx_last        = (tx_state == TX_DATA) && (tx_slot == SW'(BPL - 1));
    assign link.ready_out = (bit_cnt == 3'd7) && ((tx_state == TX_IDLE) || tx_last);
    assign accept         = link.valid_in && link.ready_out;

    // What gets loaded at the next bit_cnt==0 wrap
    always_comb begin
        tx_nstate = tx_state;
        tx_nslot  = tx_slot;
        if (tx_pend) begin
            tx_nstate = TX_STP;
        end else if (tx_state == TX_STP) begin
            tx_nstate = TX_DATA;
            tx_nslot  = '0;
        end else if (tx_state == TX_DATA && !tx_last) begin
            tx_nslot = tx_slot + SW'(1);
        end else begin
            tx_nstate = TX_IDLE;
        end
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            bit_cnt  <= '0;
            tx_state <= TX_IDLE;
            tx_slot  <= '0;
            tx_pend  <= 1'b0;
            tx_word  <= '0;
        end else begin
            bit_cnt <= bit_cnt + 3'd1;
            if (accept) begin
                tx_pend <= 1'b1;
                tx_word <= link.data_in;
            end else if (bit_cnt == 3'd0) begin
                tx_pend  <= 1'b0;
                tx_state <= tx_nstate;
                tx_slot  <= tx_nslot;
                // top LANES bytes always hold the slot about to be sent
                if (tx_nstate == TX_DATA) tx_word <= tx_word << (8 * LANES);
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_tx_lane
        logic [7:0] tx_sh;
        assign serial_out[l] = tx_sh[7];
        always_ff @(posedge clk_32f or negedge reset) begin
            if (!reset)                tx_sh <= '0;
            else if (bit_cnt == 3'd0)  tx_sh <= (tx_nstate == TX_STP)  ? STP :
                                                (tx_nstate == TX_DATA) ? tx_word[DATA_W-1-8*l -: 8] : COM;
            else                       tx_sh <= {tx_sh[6:0], 1'b0};
        end
    end

    // ---------------- RX ----------------
    logic [LANES-1:0]            is_com, is_stp;
    logic [LANES-1:0][BPL*8-1:0] lane_word;
    logic [DATA_W-1:0]           rx_word, data_q;
    logic [2:0]                  rx_cnt;
    logic [1:0]                  rx_state;
    logic [SW-1:0]               rx_slot;
    logic [BADW-1:0]             bad_cnt;
    logic                        all_com, all_stp, boundary, capture, idle_bad, valid_q, locked_q;

    assign all_com  = &is_com;
    assign all_stp  = &is_stp;
    assign boundary = (rx_cnt == 3'd7);
    assign capture  = (rx_state == RX_DATA) && boundary;
    assign idle_bad = (rx_state == RX_IDLE) && boundary && !all_stp && !all_com;

    for (genvar l = 0; l < LANES; l++) begin : g_rx_lane
        phy_lane_rx #(.BPL(BPL)) u_lane (
            .clk       (clk_32f),
            .rst_n     (reset),
            .serial_in (serial_in[l]),
            .capture   (capture),
            .is_com    (is_com[l]),
            .is_stp    (is_stp[l]),
            .lane_word (lane_word[l])
        );
    end

    for (genvar k = 0; k < DATA_W / 8; k++) begin : g_unstripe
        assign rx_word[DATA_W-1-8*k -: 8] = lane_word[k % LANES][(BPL-1-k/LANES)*8 +: 8];
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            rx_state <= RX_SEARCH;
            rx_cnt   <= '0;
            rx_slot  <= '0;
            bad_cnt  <= '0;
            locked_q <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            rx_cnt  <= rx_cnt + 3'd1;
            case (rx_state)
                RX_SEARCH: if (all_com) begin
                    rx_state <= RX_IDLE;
                    rx_cnt   <= '0;
                    bad_cnt  <= '0;
                    locked_q <= 1'b1;
                end
                RX_IDLE: begin
                    if (boundary && all_stp) begin
                        rx_state <= RX_DATA;
                        rx_slot  <= '0;
                    end else if (boundary && all_com) begin
                        bad_cnt <= '0;
                    end else if (idle_bad) begin
                        if (bad_cnt == BADW'(LOCK_LOSS - 1)) begin
                            rx_state <= RX_SEARCH;
                            locked_q <= 1'b0;
                            bad_cnt  <= '0;
                        end else begin
                            bad_cnt <= bad_cnt + BADW'(1);
                        end
                    end
                end
                RX_DATA: if (boundary) begin
                    if (rx_slot == SW'(BPL - 1)) begin
                        data_q   <= rx_word;
                        valid_q  <= 1'b1;
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_slot <= rx_slot + SW'(1);
                    end
                end
                default: rx_state <= RX_SEARCH;
            endcase
        end
    end

    assign link.data_out  = data_q;
    assign link.valid_out = valid_q;
    assign link.locked    = locked_q;
    assign dbg            = {tx_state, rx_state, bit_cnt};

`ifdef PHY_LINK_ERR_CNT_EN
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset)                          err_cnt <= '0;
        else if (idle_bad && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_phy_link_nlane.sv
// Loopback bench for phy_link_nlane: default 32b/2-lane instance plus a 64b/4-lane instance.
module tb_phy_link_nlane;
  import phy_link_nlane_pkg::*;

  localparam int LAT_A = 8 * (32 / 16 + 1) + 1;
  localparam int LAT_B = 8 * (64 / 32 + 1) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge reset)
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  phy_link_nlane_if #(.DATA_W(32)) ifa ();
  phy_link_nlane_if #(.DATA_W(64)) ifb ();
  logic [1:0] sout_a, sin_a;
  logic [3:0] sout_b;
  logic       force_zero = 1'b0;
  dbg_t       dbg_a, dbg_b;
  assign sin_a = force_zero ? 2'b00 : sout_a;
`ifdef PHY_LINK_ERR_CNT_EN
  logic [7:0] err_a, err_b;
`endif

  phy_link_nlane u_dut_a (
    .clk_32f(clk), .reset(reset), .link(ifa), .serial_out(sout_a), .serial_in(sin_a), .dbg(dbg_a)
`ifdef PHY_LINK_ERR_CNT_EN
    , .err_cnt(err_a)
`endif
  );

  phy_link_nlane #(.DATA_W(64), .LANES(4), .LOCK_LOSS(4)) u_dut_b (
    .clk_32f(clk), .reset(reset), .link(ifb), .serial_out(sout_b), .serial_in(sout_b), .dbg(dbg_b)
`ifdef PHY_LINK_ERR_CNT_EN
    , .err_cnt(err_b)
`endif
  );

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];
  int          exp_t[$];
  logic [31:0] last_a = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Every cycle out of reset: valid_out only at accept+latency, data_out holds the last delivered word.
  always @(negedge clk) begin
    if (reset) begin
      if (exp_t.size() > 0 && cyc == exp_t[0]) begin
        last_a = exp_q.pop_front();
        void'(exp_t.pop_front());
        check("valid_a", 64'(ifa.valid_out), 64'd1);
      end else begin
        check("valid_a", 64'(ifa.valid_out), 64'd0);
      end
      check("data_a", 64'(ifa.data_out), 64'(last_a));
    end
  end

  // ---------------- drivers ----------------
  task automatic send_a(input logic [31:0] w, output int t);
    int n = 0;
    t = -1;
    ifa.data_in  = w;
    ifa.valid_in = 1'b1;
    while (t < 0 && n < 100) begin
      if (ifa.ready_out) begin
        @(negedge clk);
        t = cyc;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    check("accept_a", 64'(t >= 0), 64'd1);
    if (t >= 0) begin
      exp_q.push_back(w);
      exp_t.push_back(t + LAT_A);
    end
  endtask

  task automatic send_b(input logic [63:0] w, output int t);
    int n = 0;
    t = -1;
    ifb.data_in  = w;
    ifb.valid_in = 1'b1;
    while (t < 0 && n < 100) begin
      if (ifb.ready_out) begin
        @(negedge clk);
        t = cyc;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    ifb.valid_in = 1'b0;
    check("accept_b", 64'(t >= 0), 64'd1);
  endtask

  task automatic wait_until(input int target);
    int n = 0;
    while (cyc < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("wait_cycle", 64'(cyc), 64'(target));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sout_a"}, 64'(sout_a), 64'd0);
    check({tag, "_ready_a"}, 64'(ifa.ready_out), 64'd0);
    check({tag, "_valid_a"}, 64'(ifa.valid_out), 64'd0);
    check({tag, "_data_a"}, 64'(ifa.data_out), 64'd0);
    check({tag, "_locked_a"}, 64'(ifa.locked), 64'd0);
    check({tag, "_sout_b"}, 64'(sout_b), 64'd0);
    check({tag, "_data_b"}, ifb.data_out, 64'd0);
    check({tag, "_locked_b"}, 64'(ifb.locked), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]  com_v;
    logic [15:0] l0, l3;
    int t1, t2, t3, t4, t5, tb_acc, bstart, n;
    com_v = 8'hBC;
    l0 = '0;
    l3 = '0;
    ifa.data_in = '0;
    ifa.valid_in = 1'b0;
    ifb.data_in = '0;
    ifb.valid_in = 1'b0;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;

    // Idle loopback: COM on every lane from the first cycle, ready on bit 7, lock by cycle 16
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      check("idle_serial", 64'(sout_a), 64'({2{com_v[7 - ((i - 1) % 8)]}}));
      check("idle_ready", 64'(ifa.ready_out), 64'((i % 8) == 7));
      if (i == 1)  check("locked_early", 64'(ifa.locked), 64'd0);
      if (i == 16) check("locked_by_16", 64'(ifa.locked), 64'd1);
    end

    // Single word
    send_a(32'hDEADBEEF, t1);
    ifa.valid_in = 1'b0;
    wait_until(t1 + 25);
    check("single_valid", 64'(ifa.valid_out), 64'd1);
    check("single_data", 64'(ifa.data_out), 64'hDEADBEEF);

    // Back-to-back, payload contains COM/STP byte values
    send_a(32'h01020304, t2);
    send_a(32'hBCFBBCFB, t3);
    ifa.valid_in = 1'b0;
    check("b2b_spacing", 64'(t3 - t2), 64'd24);
    wait_until(t3 + LAT_A + 1);
    check("b2b_last", 64'(ifa.data_out), 64'hBCFBBCFB);

    // Four-lane 64-bit instance: lane byte order and reassembly
    send_b(64'h0011223344556677, tb_acc);
    for (int i = 1; i <= LAT_B + 1; i++) begin
      @(negedge clk);
      if (i >= 9 && i <= 24) begin
        l0 = {l0[14:0], sout_b[0]};
        l3 = {l3[14:0], sout_b[3]};
      end
      check("valid_b", 64'(ifb.valid_out), 64'(i == LAT_B));
    end
    check("lane0_bytes", 64'(l0), 64'h0044);
    check("lane3_bytes", 64'(l3), 64'h3377);
    check("data_b", ifb.data_out, 64'h0011223344556677);

    // Lock loss: zeros from just after a byte boundary, loss on the 4th bad boundary
    n = 0;
    while ((cyc % 8) != 1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    force_zero = 1'b1;
    bstart = cyc;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (i == 31) check("lock_hold", 64'(ifa.locked), 64'd1);
      if (i == 32) check("lock_lost", 64'(ifa.locked), 64'd0);
    end
    force_zero = 1'b0;
    check("loss_window", 64'(cyc - bstart), 64'd32);
`ifdef PHY_LINK_ERR_CNT_EN
    check("err_cnt", 64'(err_a), 64'd4);
`endif
    n = 0;
    while (!ifa.locked && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("relock", 64'(ifa.locked), 64'd1);
    send_a(32'hCAFEF00D, t4);
    ifa.valid_in = 1'b0;
    wait_until(t4 + LAT_A + 1);
    check("relock_word", 64'(ifa.data_out), 64'hCAFEF00D);

    // Reset in the middle of a word's payload
    send_a(32'h12345678, t5);
    ifa.valid_in = 1'b0;
    wait_until(t5 + 12);
    #2 reset = 1'b0;
    #1;
    exp_q.delete();
    exp_t.delete();
    last_a = '0;
    check_all_zero("midreset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (16) @(negedge clk);
    check("relock_after_reset", 64'(ifa.locked), 64'd1);
    repeat (24) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
